// File: rtl/add_pkg.sv
// Shared definitions for the chunked pipelined adder/subtractor.
// Holds the default geometry, the stage-count helper and the per-stage
// pipeline record. Record fields are sized for the widest supported
// operand; each instance uses only the low WIDTH bits.
package add_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned CHUNK_DEF   = 8;
  localparam int unsigned STAGE_W_MAX = 128;

  // One pipeline stage: valid, carry into the next slice, result slices
  // resolved so far, and the operand slices still waiting for their stage.
  typedef struct packed {
    logic                   valid;
    logic                   carry;
    logic [STAGE_W_MAX-1:0] sum;
    logic [STAGE_W_MAX-1:0] a;
    logic [STAGE_W_MAX-1:0] b;
  } stage_t;

  function automatic int unsigned stages_of(input int unsigned width,
                                            input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports: a, b   - operand slices
//        cin    - carry into the slice LSB
//        s      - sum slice
//        cout   - carry out of the slice MSB
//        a_msb, b_msb - slice MSB operand bits (for signed overflow)
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb
);

  // Bit-serial ripple: each bit consumes the carry of the bit below.
  always_comb begin : ripple
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

  assign a_msb = a[CHUNK-1];
  assign b_msb = b[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: one CHUNK-bit ripple slice per stage, carry
// registered between stages, valid/ready handshake with global stall.
// Optional flags: define ADD_PIPE_FLAGS_EN to compute ovf/zero; otherwise
// they are tied low.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, a, b, sub, cin      - operand beat
//        out_valid/out_ready, sum, cout, ovf, zero - result beat
module add_pipe
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);
  localparam int unsigned LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH > STAGE_W_MAX) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a multiple of CHUNK and at most STAGE_W_MAX");
  end

  stage_t           src    [STAGES];
  stage_t           nxt    [STAGES];
  stage_t           rec    [STAGES];
  logic [CHUNK-1:0] s_arr  [STAGES];
  logic             co_arr [STAGES];
  logic             am_arr [STAGES];
  logic             bm_arr [STAGES];
  logic             adv;

  // Whole pipeline moves when the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 takes prepared operands (zeroed for bubbles so
  // an idle pipe presents sum = 0), later stages take the previous register.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      src[k] = '0;
    end
    src[0].valid = in_valid;
    if (in_valid) begin
      src[0].carry = sub | cin;
      src[0].a     = STAGE_W_MAX'(a);
      src[0].b     = STAGE_W_MAX'(sub ? ~b : b);
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      src[k] = rec[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (src[k].a[k*CHUNK +: CHUNK]),
      .b     (src[k].b[k*CHUNK +: CHUNK]),
      .cin   (src[k].carry),
      .s     (s_arr[k]),
      .cout  (co_arr[k]),
      .a_msb (am_arr[k]),
      .b_msb (bm_arr[k])
    );
  end

  // Merge each stage's resolved slice and carry into its record.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt[k]                       = src[k];
      nxt[k].sum[k*CHUNK +: CHUNK] = s_arr[k];
      nxt[k].carry                 = co_arr[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        rec[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        rec[k] <= nxt[k];
      end
    end
  end

  // The last record doubles as the output register.
  assign out_valid = rec[LAST].valid;
  assign sum       = rec[LAST].sum[WIDTH-1:0];
  assign cout      = rec[LAST].carry;

`ifdef ADD_PIPE_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // Flags come from the MSB stage, registered alongside the final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= nxt[LAST].valid && (am_arr[LAST] == bm_arr[LAST]) &&
                (s_arr[LAST][CHUNK-1] != am_arr[LAST]);
      zero_q <= nxt[LAST].valid && (nxt[LAST].sum[WIDTH-1:0] == '0);
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  logic flags_unused;
  assign flags_unused = am_arr[LAST] ^ bm_arr[LAST];
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Directed and randomised checks of add_pipe in a 32/8 four-stage build
// and a 16/16 single-stage build sharing one clock and reset.
module tb_add_pipe;

`ifdef ADD_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, sub1, cin1, out_valid1, out_ready1;
  logic        cout1, ovf1, zero1;
  logic [31:0] a1, b1, sum1;

  logic        in_valid2, in_ready2, sub2, cin2, out_valid2, out_ready2;
  logic        cout2, ovf2, zero2;
  logic [15:0] a2, b2, sum2;

  int total = 0;
  int bad   = 0;

  add_pipe #(.WIDTH(32), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  add_pipe #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; cin1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    idle1();
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0;
    tick(); tick();
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid1); end
    total++; if (sum1 !== 32'h0) begin bad++; $display("FAIL rst_sum got=%h exp=0", sum1); end
    total++; if (cout1 !== 1'b0) begin bad++; $display("FAIL rst_cout got=%b exp=0", cout1); end
    total++; if (ovf1 !== 1'b0 || zero1 !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", ovf1, zero1); end
    total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL rst_out_valid2 got=%b exp=0", out_valid2); end
    rst = 1'b0;
    tick();
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready1); end
    total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL rst_in_ready2 got=%b exp=1", in_ready2); end
    out_ready1 = 1'b1; out_ready2 = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] ta   [10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h7, 32'hFF,
                               32'h9, 32'h80000000, 32'h80000000, 32'h12345678, 32'h5};
    logic [31:0] tb_  [10] = '{32'h1, 32'h1, 32'h7, 32'h5, 32'h0,
                               32'h3, 32'hFFFFFFFF, 32'h1, 32'h00FF00FF, 32'h5};
    logic        tsub [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        tcin [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tsum [10] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h2, 32'h100,
                               32'h6, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h13335778, 32'h0};
    logic        tco  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        tovf [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tz   [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid1 = 1'b1; a1 = ta[i]; b1 = tb_[i]; sub1 = tsub[i]; cin1 = tcin[i];
      tick();
      idle1();
      tick(); tick();
      total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL arith%0d_early got=%b exp=0", i, out_valid1); end
      tick();
      total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL arith%0d_valid got=%b exp=1", i, out_valid1); end
      total++; if (sum1 !== tsum[i]) begin bad++; $display("FAIL arith%0d_sum got=%h exp=%h", i, sum1, tsum[i]); end
      total++; if (cout1 !== tco[i]) begin bad++; $display("FAIL arith%0d_cout got=%b exp=%b", i, cout1, tco[i]); end
      total++; if (ovf1 !== (FLAGS & tovf[i])) begin bad++; $display("FAIL arith%0d_ovf got=%b exp=%b", i, ovf1, FLAGS & tovf[i]); end
      total++; if (zero1 !== (FLAGS & tz[i])) begin bad++; $display("FAIL arith%0d_zero got=%b exp=%b", i, zero1, FLAGS & tz[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      out_ready1 = !(cyc >= 5 && cyc <= 7);
      sub1 = 1'b0; cin1 = 1'b0;
      if (sent < 6) begin
        in_valid1 = 1'b1; a1 = 32'(sent); b1 = 32'(sent);
      end else begin
        in_valid1 = 1'b0; a1 = '0; b1 = '0;
      end
      #1;
      if (out_valid1 && !out_ready1) begin
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready1); end
        total++; if (sum1 !== 32'(2 * got)) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, sum1, 32'(2 * got)); end
      end
      if (out_valid1 && out_ready1) begin
        total++; if (sum1 !== 32'(2 * got)) begin bad++; $display("FAIL b2b_sum%0d got=%h exp=%h", got, sum1, 32'(2 * got)); end
        got++;
      end
      if (in_valid1 && in_ready1) sent++;
      tick();
    end
    idle1();
    total++; if (got != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", got); end
  endtask

  task automatic test_reset_mid();
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid1 = 1'b1; a1 = 32'(i + 1); b1 = 32'h1; sub1 = 1'b0; cin1 = 1'b0;
      tick();
    end
    idle1();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rstmid_valid%0d got=%b exp=0", j, out_valid1); end
      total++; if (sum1 !== 32'h0) begin bad++; $display("FAIL rstmid_sum%0d got=%h exp=0", j, sum1); end
      tick();
    end
    in_valid1 = 1'b1; a1 = 32'h10; b1 = 32'h20;
    tick();
    idle1();
    tick(); tick(); tick();
    total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_valid got=%b exp=1", out_valid1); end
    total++; if (sum1 !== 32'h30) begin bad++; $display("FAIL rstmid_fresh_sum got=%h exp=30", sum1); end
    tick();
  endtask

  task automatic test_random16();
    logic [16:0] q[$];
    logic [16:0] exp;
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    bit  acc_prev = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      out_ready2 = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        in_valid2 = ($urandom_range(0, 4) != 0);
        a2 = 16'($urandom); b2 = 16'($urandom);
        sub2 = 1'($urandom_range(0, 1)); cin2 = 1'($urandom_range(0, 1));
      end else begin
        in_valid2 = 1'b0;
      end
      #1;
      if (acc_prev) begin
        total++; if (out_valid2 !== 1'b1) begin bad++; $display("FAIL rnd_latency cyc=%0d got=%b exp=1", cyc, out_valid2); end
      end
      if (out_valid2 && out_ready2) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, sum2);
        end else begin
          exp = q.pop_front();
          if ({cout2, sum2} !== exp) begin bad++; $display("FAIL rnd_result%0d got=%h exp=%h", got, {cout2, sum2}, exp); end
        end
        got++;
      end
      acc_prev = in_valid2 && in_ready2;
      if (acc_prev) begin
        if (sub2) exp = {(a2 >= b2), 16'(a2 - b2)};
        else      exp = 17'(a2) + 17'(b2) + 17'(cin2);
        q.push_back(exp);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid2 = 1'b0;
    total++; if (got != 1000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=1000", got); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
